wb_arbiter: RTL and testbench

Writeback stage directly upstream of the regfile write port. Merges single-cycle results from the MW pipeline register with results from the multi-cycle mult/div unit. Issues at most one registered write per cycle on ctrl_writeEn / ctrl_writeReg / data_writeReg. Keeps a busy scoreboard of in-flight mult/div destinations, which decode uses to stall.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_md_fifo.sv | 73 +++++++
 rtl/wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and result entry type for the writeback arbiter
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_md_fifo.sv
// rtl/wb_md_fifo.sv - synchronous FIFO of mult/div results with count, full and empty
module wb_md_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        pop_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_entry = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next storage, pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset empties the queue
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging pipeline and mult/div results; WB_BYPASS_EN adds byp_* forwarding outputs
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0]     pipe_data,
  output logic                  pipe_stall,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  input  logic                  issue_md_valid,
  input  logic [REG_ADDR_W-1:0] issue_md_rd,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic                  ctrl_writeEn,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg
`ifdef WB_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [REG_ADDR_W-1:0] byp_rd,
  output logic [DATA_W-1:0]     byp_data
`endif
);

  localparam int CNT_W    = $clog2(MD_DEPTH) + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             md_entry;
  wb_entry_t             head_entry;
  wb_entry_t             sel_entry;
  logic                  sel_valid;
  logic                  md_push;
  logic                  md_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  assign md_entry  = {md_rd, md_data};
  assign md_ready  = !fifo_full;
  assign md_push   = md_valid && md_ready;

  assign busy_mask     = busy_q;
  assign ctrl_writeEn  = wen_q;
  assign ctrl_writeReg = wreg_q;
  assign data_writeReg = wdata_q;

  wb_md_fifo #(
    .DEPTH (MD_DEPTH)
  ) u_md_fifo (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .push       (md_push),
    .push_entry (md_entry),
    .pop        (md_pop),
    .pop_entry  (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Select this cycle's writer: pipeline by default, FIFO head when the pipe is idle or the head has starved
  always_comb begin
    md_pop     = 1'b0;
    sel_valid  = 1'b0;
    sel_entry  = {pipe_rd, pipe_data};
    pipe_stall = 1'b0;
    if (!fifo_empty && (!pipe_valid || (starve_q == STARVE_W'(STARVE_LIMIT)))) begin
      md_pop     = 1'b1;
      sel_valid  = 1'b1;
      sel_entry  = head_entry;
      pipe_stall = pipe_valid;
    end else if (pipe_valid) begin
      sel_valid = 1'b1;
    end
  end

  // Count cycles a waiting head loses to the pipeline; saturates at the preemption threshold
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || md_pop) begin
      starve_d = '0;
    end else if (pipe_valid && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Register the selected entry; $0 results are consumed without a write, address/data hold when idle
  always_comb begin
    wen_d   = sel_valid && (sel_entry.rd != '0);
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (sel_valid) begin
      wreg_d  = sel_entry.rd;
      wdata_d = sel_entry.data;
    end
  end

  // Pending mult/div destinations: pop clears, issue sets (set wins), $0 never busy
  always_comb begin
    busy_d = busy_q;
    if (md_pop) begin
      busy_d[head_entry.rd] = 1'b0;
    end
    if (issue_md_valid && (issue_md_rd != '0)) begin
      busy_d[issue_md_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers for starve counter, scoreboard and regfile write port
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      starve_q <= '0;
      busy_q   <= '0;
      wen_q    <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = sel_valid && (sel_entry.rd != '0);
  assign byp_rd    = sel_entry.rd;
  assign byp_data  = sel_entry.data;
`endif

  // Decode stalls on busy registers, so the pipeline never writes a pending mult/div destination
  a_pipe_rd_not_busy: assert property (@(posedge clock) disable iff (!ctrl_reset)
    !(pipe_valid && (pipe_rd != '0) && busy_q[pipe_rd]));

  a_fifo_count_bound: assert property (@(posedge clock) disable iff (!ctrl_reset)
    fifo_count <= CNT_W'(MD_DEPTH));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;
  import wb_pkg::*;

  logic                  clock = 1'b0;
  logic                  ctrl_reset = 1'b0;
  logic                  pipe_valid;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0]     pipe_data;
  logic                  pipe_stall;
  logic                  md_valid;
  logic [REG_ADDR_W-1:0] md_rd;
  logic [DATA_W-1:0]     md_data;
  logic                  md_ready;
  logic                  issue_md_valid;
  logic [REG_ADDR_W-1:0] issue_md_rd;
  logic [NUM_REGS-1:0]   busy_mask;
  logic                  ctrl_writeEn;
  logic [REG_ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0]     data_writeReg;

  int tests_run = 0;
  int tests_failed = 0;
  wb_entry_t exp_q[$];

  wb_arbiter #(.MD_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .pipe_valid     (pipe_valid),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .pipe_stall     (pipe_stall),
    .md_valid       (md_valid),
    .md_rd          (md_rd),
    .md_data        (md_data),
    .md_ready       (md_ready),
    .issue_md_valid (issue_md_valid),
    .issue_md_rd    (issue_md_rd),
    .busy_mask      (busy_mask),
    .ctrl_writeEn   (ctrl_writeEn),
    .ctrl_writeReg  (ctrl_writeReg),
    .data_writeReg  (data_writeReg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Monitor: every regfile write must match the oldest expected write
  always @(negedge clock) begin
    if (ctrl_reset === 1'b1 && ctrl_writeEn === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", ctrl_writeReg, data_writeReg);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        if (ctrl_writeReg !== e.rd || data_writeReg !== e.data) begin
          tests_failed++;
          $display("FAIL write_order: got rd=%0d data=%h expected rd=%0d data=%h",
                   ctrl_writeReg, data_writeReg, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    pipe_valid = 1'b1; pipe_rd = 5'd7; pipe_data = 32'h7777_7777;
    md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h8888_8888;
    issue_md_valid = 1'b1; issue_md_rd = 5'd8;

    // Reset with all inputs active
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wen", {31'd0, ctrl_writeEn}, 32'd0);
    chk("rst_wreg", {27'd0, ctrl_writeReg}, 32'd0);
    chk("rst_wdata", data_writeReg, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    pipe_valid = 1'b0; md_valid = 1'b0; issue_md_valid = 1'b0;
    ctrl_reset = 1'b1;
    step();
    chk("idle_wen", {31'd0, ctrl_writeEn}, 32'd0);

    // Pipe only
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h0000_DEAD;
    expect_wr(5'd5, 32'h0000_DEAD);
    #1 chk("pipe_stall0", {31'd0, pipe_stall}, 32'd0);
    step();
    pipe_valid = 1'b0;
    step();

    // Mult/div lifecycle
    issue_md_valid = 1'b1; issue_md_rd = 5'd9;
    step();
    issue_md_valid = 1'b0;
    chk("md_busy_set", busy_mask, 32'h0000_0200);
    step();
    chk("md_busy_hold", busy_mask, 32'h0000_0200);
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h1234_5678;
    expect_wr(5'd9, 32'h1234_5678);
    #1 chk("md_ready_empty", {31'd0, md_ready}, 32'd1);
    step();
    md_valid = 1'b0;
    chk("md_busy_pre_wr", busy_mask, 32'h0000_0200);
    chk("md_no_stall", {31'd0, pipe_stall}, 32'd0);
    step();
    chk("md_busy_clr", busy_mask, 32'd0);
    step();

    // Starvation: head rd=3 waits behind four pipe writes
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'hABCD_0003;
    step();
    md_valid = 1'b0;
    begin
      logic [4:0] rds [4];
      rds = '{5'd1, 5'd2, 5'd4, 5'd6};
      for (int i = 0; i < 4; i++) begin
        pipe_valid = 1'b1; pipe_rd = rds[i]; pipe_data = 32'h100 + 32'(rds[i]);
        expect_wr(rds[i], 32'h100 + 32'(rds[i]));
        #1 chk("starve_no_stall", {31'd0, pipe_stall}, 32'd0);
        step();
      end
    end
    pipe_rd = 5'd7; pipe_data = 32'h107;
    #1 chk("starve_stall", {31'd0, pipe_stall}, 32'd1);
    expect_wr(5'd3, 32'hABCD_0003);
    step();
    chk("starve_resume", {31'd0, pipe_stall}, 32'd0);
    expect_wr(5'd7, 32'h107);
    step();
    pipe_valid = 1'b0;
    step();

    // Full FIFO: third result held while pipe streams
    pipe_valid = 1'b1; pipe_rd = 5'd10; pipe_data = 32'h10A;
    md_valid = 1'b1; md_rd = 5'd20; md_data = 32'hA000_0020;
    expect_wr(5'd10, 32'h10A);
    step();
    pipe_rd = 5'd11; pipe_data = 32'h10B;
    md_rd = 5'd21; md_data = 32'hB000_0021;
    expect_wr(5'd11, 32'h10B);
    #1 chk("full_ready1", {31'd0, md_ready}, 32'd1);
    step();
    pipe_rd = 5'd12; pipe_data = 32'h10C;
    md_rd = 5'd22; md_data = 32'hC000_0022;
    expect_wr(5'd12, 32'h10C);
    #1 chk("full_ready0", {31'd0, md_ready}, 32'd0);
    step();
    pipe_rd = 5'd13; pipe_data = 32'h10D;
    expect_wr(5'd13, 32'h10D);
    #1 chk("full_ready0b", {31'd0, md_ready}, 32'd0);
    step();
    pipe_rd = 5'd14; pipe_data = 32'h10E;
    expect_wr(5'd14, 32'h10E);
    #1 chk("full_no_stall", {31'd0, pipe_stall}, 32'd0);
    step();
    pipe_rd = 5'd15; pipe_data = 32'h10F;
    #1;
    chk("full_stall", {31'd0, pipe_stall}, 32'd1);
    chk("full_ready_pop", {31'd0, md_ready}, 32'd0);
    expect_wr(5'd20, 32'hA000_0020);
    step();
    chk("full_stall_rel", {31'd0, pipe_stall}, 32'd0);
    chk("full_ready_again", {31'd0, md_ready}, 32'd1);
    expect_wr(5'd15, 32'h10F);
    step();
    pipe_valid = 1'b0; md_valid = 1'b0;
    expect_wr(5'd21, 32'hB000_0021);
    step();
    expect_wr(5'd22, 32'hC000_0022);
    step();
    step();

    // $0 handling
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF_FFFF;
    issue_md_valid = 1'b1; issue_md_rd = 5'd0;
    step();
    pipe_valid = 1'b0; issue_md_valid = 1'b0;
    chk("zero_busy", busy_mask, 32'd0);
    chk("zero_pipe_wen", {31'd0, ctrl_writeEn}, 32'd0);
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
    step();
    md_valid = 1'b0;
    step();
    chk("zero_md_wen", {31'd0, ctrl_writeEn}, 32'd0);
    chk("zero_busy2", busy_mask, 32'd0);
    step();

    // Set and clear of the same busy bit in one cycle: set wins
    issue_md_valid = 1'b1; issue_md_rd = 5'd9;
    step();
    issue_md_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    expect_wr(5'd9, 32'h99);
    step();
    md_valid = 1'b0;
    issue_md_valid = 1'b1; issue_md_rd = 5'd9;
    step();
    issue_md_valid = 1'b0;
    chk("set_wins", busy_mask, 32'h0000_0200);
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h98;
    expect_wr(5'd9, 32'h98);
    step();
    md_valid = 1'b0;
    step();
    chk("set_wins_clr", busy_mask, 32'd0);
    step();

    // Reset mid-operation discards FIFO contents and busy bits
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h201;
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'hC;
    issue_md_valid = 1'b1; issue_md_rd = 5'd12;
    expect_wr(5'd1, 32'h201);
    step();
    pipe_valid = 1'b0; md_valid = 1'b0; issue_md_valid = 1'b0;
    chk("mid_busy", busy_mask, 32'h0000_1000);
    @(negedge clock);
    #1 ctrl_reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy_mask, 32'd0);
    chk("mid_rst_wen", {31'd0, ctrl_writeEn}, 32'd0);
    step();
    ctrl_reset = 1'b1;
    repeat (3) step();
    chk("mid_no_write", {31'd0, ctrl_writeEn}, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
